// File: rtl/pipe_chain_rw.sv
// Parametrised pipeline register chain with per-stage valid, stall and flush.
// Each stage either holds (back-pressures upstream) or bubbles on stall.
module pipe_chain_rw #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [DEPTH-1:0] HOLD_MASK = {DEPTH{1'b1}},
    parameter int CNT_W = 16,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DEPTH-1:0] stall,
    input  logic [DEPTH-1:0] flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occupancy,
    output logic [CNT_W-1:0] dropped
);

    localparam int IW = $clog2(2 * DEPTH + 1);
    localparam int SW = CNT_W + IW;

    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data [DEPTH];

    logic [DEPTH-1:0] stall_eff;
    logic             se_chain;

    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d [DEPTH];
    logic [DEPTH-1:0] up_hold;
    logic [DEPTH-1:0] up_free;

    logic [DEPTH-1:0] nv;
    logic [WIDTH-1:0] nd [DEPTH];
    logic [IW-1:0]    inc;
    logic [SW-1:0]    sum;
    logic [CNT_W-1:0] dropped_nxt;

    // Back-pressure walks upstream only while it crosses HOLD stages
    always_comb begin
        stall_eff = '0;
        se_chain = stall[DEPTH-1] | (valid[DEPTH-1] & ~out_ready);
        stall_eff[DEPTH-1] = se_chain;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            se_chain = stall[i] | (HOLD_MASK[i+1] & se_chain);
            stall_eff[i] = se_chain;
        end
    end

    always_comb begin
        src_v = '0;
        up_hold = '0;
        up_free = '0;
        for (int i = 0; i < DEPTH; i++) src_d[i] = '0;
        src_v[0] = in_valid;
        src_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = valid[i-1];
            src_d[i] = data[i-1];
            up_hold[i] = stall_eff[i-1] & HOLD_MASK[i-1];
            up_free[i] = valid[i-1] & ~stall_eff[i-1];
        end
    end

    always_comb begin
        nv = '0;
        inc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            nd[i] = '0;
            if (clear | flush[i]) begin
                inc = inc + IW'(valid[i]);
            end else if (stall_eff[i]) begin
                if (HOLD_MASK[i]) begin
                    nv[i] = valid[i];
                    nd[i] = data[i];
                end else begin
                    // Zeroing stage loses its own word and any word shifted in
                    inc = inc + IW'(valid[i]) + IW'(up_free[i]);
                end
            end else if (!up_hold[i] && src_v[i]) begin
                nv[i] = 1'b1;
                nd[i] = src_d[i];
            end
        end
    end

    always_comb begin
        sum = SW'(dropped) + SW'(inc);
        dropped_nxt = (|sum[SW-1:CNT_W]) ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) data[i] <= '0;
            dropped <= '0;
        end else begin
            valid <= nv;
            for (int i = 0; i < DEPTH; i++) data[i] <= nd[i];
            dropped <= dropped_nxt;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++)
            occupancy = occupancy + OCC_W'(valid[i]);
    end

    assign in_ready  = ~stall_eff[0];
    assign out_valid = valid[DEPTH-1];
    assign out_data  = data[DEPTH-1];

endmodule

// File: tb/tb_pipe_chain_rw.sv
// Directed bench for pipe_chain_rw: an all-HOLD chain with a scoreboard
// and a mixed HOLD/BUBBLE chain sharing the same stimulus.
module tb_pipe_chain_rw;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [3:0]  stall;
    logic [3:0]  flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready_a, out_valid_a;
    logic [31:0] out_data_a;
    logic [2:0]  occ_a;
    logic [15:0] dropped_a;

    logic        in_ready_b, out_valid_b;
    logic [31:0] out_data_b;
    logic [2:0]  occ_b;
    logic [15:0] dropped_b;

    int tests = 0;
    int fails = 0;
    bit sb_en = 1'b0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    pipe_chain_rw #(.WIDTH(32), .DEPTH(4), .HOLD_MASK(4'b1111), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready),
        .occupancy(occ_a), .dropped(dropped_a)
    );

    pipe_chain_rw #(.WIDTH(32), .DEPTH(4), .HOLD_MASK(4'b1011), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready),
        .occupancy(occ_b), .dropped(dropped_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] d, input bit push);
        in_valid = 1'b1;
        in_data = d;
        if (push) sb.push_back(d);
    endtask

    // Scoreboard: pop on every consumed output word of the all-HOLD chain
    always @(negedge clk) begin
        if (sb_en && out_valid_a && out_ready && !stall[3]) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", {32'b0, out_data_a}, 64'hdead_beef);
            end else begin
                chk("sb_out_data", {32'b0, out_data_a}, {32'b0, sb.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1; clear = 1'b0; stall = '0; flush = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        step();
        chk("rst_occ", occ_a, 0);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_out_data", out_data_a, 0);
        chk("rst_dropped", dropped_a, 0);
        chk("rst_in_ready", in_ready_a, 1);
        rst = 1'b0;
        sb_en = 1'b1;

        // stream 1..5 with no stalls
        for (int k = 1; k <= 4; k++) begin
            offer(k, 1'b1);
            step();
        end
        chk("t1_latency_data", out_data_a, 1);
        chk("t1_latency_valid", out_valid_a, 1);
        chk("t1_occ_full", occ_a, 4);
        offer(5, 1'b1);
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("t1_drained_occ", occ_a, 0);
        chk("t1_sb_empty", sb.size(), 0);

        // full pipe, consumer stalls 3 cycles
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            offer(k, 1'b1);
            step();
        end
        offer(99, 1'b0);
        #1;
        chk("t2_in_ready_low", in_ready_a, 0);
        repeat (3) step();
        chk("t2_hold_data", out_data_a, 1);
        chk("t2_hold_occ", occ_a, 4);
        chk("t2_dropped", dropped_a, 0);
        chk("t2_in_ready_still", in_ready_a, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        chk("t2_drained_occ", occ_a, 0);
        chk("t2_sb_empty", sb.size(), 0);

        // HOLD stall on stage 1 -> two bubbles reach the output
        for (int k = 10; k <= 12; k++) begin
            offer(k, 1'b1);
            step();
        end
        stall = 4'b0010;
        offer(13, 1'b0);
        #1;
        chk("t4_in_ready_low", in_ready_a, 0);
        step();
        chk("t4_valid_f4", out_valid_a, 1);
        step();
        chk("t4_valid_f5", out_valid_a, 0);
        stall = '0;
        offer(13, 1'b1);
        step();
        chk("t4_valid_f6", out_valid_a, 0);
        offer(14, 1'b1);
        step();
        chk("t4_valid_f7", out_valid_a, 1);
        in_valid = 1'b0;
        repeat (4) step();
        chk("t4_sb_empty", sb.size(), 0);

        // flush beats stall on output stage, then global clear
        out_ready = 1'b0;
        for (int k = 20; k <= 23; k++) begin
            offer(k, 1'b1);
            step();
        end
        in_valid = 1'b0;
        flush = 4'b1000;
        stall = 4'b1000;
        step();
        void'(sb.pop_front());
        chk("t5_flush_dropped", dropped_a, 1);
        chk("t5_flush_occ", occ_a, 3);
        chk("t5_flush_out_valid", out_valid_a, 0);
        flush = '0;
        stall = '0;
        offer(24, 1'b1);
        step();
        in_valid = 1'b0;
        chk("t5_refill_occ", occ_a, 4);
        clear = 1'b1;
        step();
        clear = 1'b0;
        sb.delete();
        chk("t5_clear_occ", occ_a, 0);
        chk("t5_clear_dropped", dropped_a, 5);
        chk("t5_clear_out_valid", out_valid_a, 0);
        out_ready = 1'b1;

        // async reset in the middle of a stall
        offer(30, 1'b0);
        step();
        offer(31, 1'b0);
        step();
        in_valid = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t6_dropped7", dropped_a, 7);
        offer(40, 1'b0);
        step();
        offer(41, 1'b0);
        step();
        stall = 4'b1111;
        step();
        chk("t6_stall_occ", occ_a, 2);
        chk("t6_stall_in_ready", in_ready_a, 0);
        #1 rst = 1'b1;
        #1;
        chk("t6_async_occ", occ_a, 0);
        chk("t6_async_dropped", dropped_a, 0);
        chk("t6_async_out_data", out_data_a, 0);
        stall = '0;
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("t6_in_ready_release", in_ready_a, 1);

        // mixed chain: BUBBLE stage 2 stalls, upstream keeps flowing
        sb_en = 1'b0;
        sb.delete();
        step();
        offer(5, 1'b0);
        step();
        offer(32'hA, 1'b0);
        step();
        offer(32'hB, 1'b0);
        step();
        stall = 4'b0100;
        offer(32'hC, 1'b0);
        #1;
        chk("t3_in_ready_b", in_ready_b, 1);
        step();
        chk("t3_dropped_b", dropped_b, 2);
        chk("t3_occ_b", occ_b, 3);
        chk("t3_out_data_b", out_data_b, 5);
        stall = '0;
        in_valid = 1'b0;
        step();
        chk("t3_gap_b", out_valid_b, 0);
        step();
        chk("t3_next_b", out_data_b, 32'hB);
        chk("t3_next_valid_b", out_valid_b, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
